// File: rtl/uart_gesture_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) that decodes
// ASCII gesture codes CMD_BASE..CMD_BASE+3 into a registered 2-bit Ctrl word.
module uart_gesture_rx #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [7:0]  CMD_BASE     = 8'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_err,
    output logic [1:0] Ctrl,
    output logic       ctrl_update,
    output logic       busy
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [15:0] baud_q, baud_d;
    logic [15:0] bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        cmd_err_q, cmd_err_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ctrl_update_q, ctrl_update_d;
    logic        busy_q, busy_d;
    logic        par_err_q, par_err_d;
    logic        line;
    logic [8:0]  cmd_off;

    assign line    = sync2_q;
    assign cmd_off = {1'b0, rx_data_q} - {1'b0, CMD_BASE};

    always_comb begin
        state_d       = state_q;
        baud_d        = baud_q + 16'd1;
        bitn_d        = bitn_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        frame_err_d   = 1'b0;
        cmd_err_d     = 1'b0;
        ctrl_d        = ctrl_q;
        ctrl_update_d = 1'b0;
        par_err_d     = par_err_q;

        case (state_q)
            S_IDLE: begin
                baud_d    = 16'd0;
                par_err_d = 1'b0;
                if (!line) state_d = S_START;
            end
            S_START: begin
                // Mid-start resample rejects glitches shorter than half a bit
                if (baud_q == HALF_LAST) state_d = line ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = 16'd0;
                    shift_d = {line, shift_q[7:1]};
                    bitn_d  = bitn_q + 16'd1;
                    if (bitn_q == 16'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_q == BIT_LAST) begin
                    par_err_d = ^{shift_q, line};
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == BIT_LAST) begin
                    if (line) begin
                        state_d = S_IDLE;
                        if (par_err_q) begin
                            frame_err_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = shift_q;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                baud_d = 16'd0;
                if (line) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            baud_d = 16'd0;
            bitn_d = 16'd0;
        end

        // Decode the byte published on the previous cycle
        if (rx_valid_q) begin
            if (cmd_off < 9'd4) begin
                ctrl_d        = cmd_off[1:0];
                ctrl_update_d = 1'b1;
            end else begin
                cmd_err_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            baud_q        <= 16'd0;
            bitn_q        <= 16'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            cmd_err_q     <= 1'b0;
            ctrl_q        <= 2'b00;
            ctrl_update_q <= 1'b0;
            busy_q        <= 1'b0;
            par_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= rx_pin;
            sync2_q       <= sync1_q;
            baud_q        <= baud_d;
            bitn_q        <= bitn_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            cmd_err_q     <= cmd_err_d;
            ctrl_q        <= ctrl_d;
            ctrl_update_q <= ctrl_update_d;
            busy_q        <= busy_d;
            par_err_q     <= par_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign cmd_err     = cmd_err_q;
    assign Ctrl        = ctrl_q;
    assign ctrl_update = ctrl_update_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_gesture_rx.sv
// Directed bench for uart_gesture_rx at CLKS_PER_BIT=16; sends a parity bit
// when UART_RX_PARITY_EN is defined.
module tb_uart_gesture_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, cmd_err, ctrl_update, busy;
    logic [1:0] Ctrl;

    uart_gesture_rx #(.CLKS_PER_BIT(CPB), .CMD_BASE(8'h30)) dut (
        .clk(clk), .rst(rst), .rx_pin(rx_pin), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .cmd_err(cmd_err),
        .Ctrl(Ctrl), .ctrl_update(ctrl_update), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse monitor, sampled on the falling edge
    int         valid_cnt = 0, ferr_cnt = 0, cerr_cnt = 0, upd_cnt = 0;
    int         lag_ok = 0, excl_viol = 0;
    logic [7:0] last_data = 8'h00;
    logic [1:0] upd_vals [0:15];
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = rx_data;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (cmd_err) cerr_cnt = cerr_cnt + 1;
        if (ctrl_update) begin
            if (prev_valid) lag_ok = lag_ok + 1;
            upd_vals[upd_cnt % 16] = Ctrl;
            upd_cnt = upd_cnt + 1;
        end
        if (32'(rx_valid) + 32'(frame_err) + 32'(cmd_err) > 1) excl_viol = excl_viol + 1;
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert = n_assert + 1;
        assert (obs === expv) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_bit(input logic v);
        rx_pin = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`else
        if (par_flip) rx_pin = 1'b1;
`endif
        send_bit(stop_v);
        rx_pin = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    int v0, f0, c0, u0;

    initial begin
        // Reset state
        repeat (4) @(negedge clk);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_ctrl", 32'(Ctrl), 32'd0);
        check("rst_ctrl_update", 32'(ctrl_update), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("step: reset released");

        // Good frame 0x32 -> Ctrl 2'b10
        send_frame(8'h32, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t1_rx_data", 32'(last_data), 32'h32);
        check("t1_ctrl", 32'(Ctrl), 32'd2);
        check("t1_upd_cnt", 32'(upd_cnt), 32'd1);
        check("t1_upd_lag", 32'(lag_ok), 32'd1);
        check("t1_ferr", 32'(ferr_cnt), 32'd0);
        check("t1_cerr", 32'(cerr_cnt), 32'd0);
        $display("step: 0x32 -> Ctrl=%b", Ctrl);

        // 4-cycle glitch
        rx_pin = 1'b0;
        repeat (4) @(negedge clk);
        rx_pin = 1'b1;
        wait_idle("t2_busy_drop", 8);
        repeat (2 * CPB) @(negedge clk);
        check("t2_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t2_ferr", 32'(ferr_cnt), 32'd0);
        check("t2_cerr", 32'(cerr_cnt), 32'd0);
        $display("step: glitch rejected");

        // Bad stop bit then held-low line
        send_frame(8'h31, 1'b0, 1'b0);
        rx_pin = 1'b0;
        repeat (40) @(negedge clk);
        rx_pin = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t3_ferr", 32'(ferr_cnt), 32'd1);
        check("t3_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t3_ctrl_held", 32'(Ctrl), 32'd2);
        check("t3_rx_data_held", 32'(rx_data), 32'h32);
        check("t3_busy", 32'(busy), 32'd0);
        send_frame(8'h33, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_ctrl_after", 32'(Ctrl), 32'd3);
        check("t3_valid_after", 32'(valid_cnt), 32'd2);
        $display("step: framing error then 0x33 -> Ctrl=%b", Ctrl);

        // Non-gesture byte
        u0 = upd_cnt;
        send_frame(8'h41, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t4_rx_data", 32'(last_data), 32'h41);
        check("t4_cerr", 32'(cerr_cnt), 32'd1);
        check("t4_ctrl_held", 32'(Ctrl), 32'd3);
        check("t4_no_update", 32'(upd_cnt), 32'(u0));
        $display("step: 0x41 -> cmd_err");

        // Back-to-back frames
        u0 = upd_cnt;
        send_frame(8'h30, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t5_valid_cnt", 32'(valid_cnt), 32'd5);
        check("t5_upd_cnt", 32'(upd_cnt), 32'(u0 + 2));
        check("t5_ctrl_first", 32'(upd_vals[u0 % 16]), 32'd0);
        check("t5_ctrl_second", 32'(upd_vals[(u0 + 1) % 16]), 32'd3);
        check("t5_rx_data", 32'(last_data), 32'h33);
        $display("step: back-to-back 0x30,0x33");

        // Reset at data bit 4 of 0x32
        v0 = valid_cnt; f0 = ferr_cnt; c0 = cerr_cnt; u0 = upd_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(((8'h32 >> i) & 8'h01) != 8'h00);
        rx_pin = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_busy_in_rst", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("t6_no_valid", 32'(valid_cnt), 32'(v0));
        check("t6_no_ferr", 32'(ferr_cnt), 32'(f0));
        check("t6_no_cerr", 32'(cerr_cnt), 32'(c0));
        check("t6_no_update", 32'(upd_cnt), 32'(u0));
        check("t6_ctrl_reset", 32'(Ctrl), 32'd0);
        send_frame(8'h31, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("t6_ctrl_after", 32'(Ctrl), 32'd1);
        check("t6_rx_data", 32'(last_data), 32'h31);
        $display("step: mid-frame reset then 0x31 -> Ctrl=%b", Ctrl);

`ifdef UART_RX_PARITY_EN
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h32, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t7_par_ferr", 32'(ferr_cnt), 32'(f0 + 1));
        check("t7_par_no_valid", 32'(valid_cnt), 32'(v0));
        check("t7_par_ctrl_held", 32'(Ctrl), 32'd1);
        check("t7_par_rx_data", 32'(rx_data), 32'h31);
        $display("step: parity error rejected");
`endif

        check("exclusive_pulses", 32'(excl_viol), 32'd0);
        check("ctrl_update_lag", 32'(lag_ok), 32'(upd_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
